gnrl_sync_fifo: RTL and testbench
=================================

Name: gnrl_sync_fifo

Overview:
Parameterized synchronous FIFO with valid/ready handshakes on both ends. It decouples a producer (write side) from a consumer (read side) between CPU pipeline stages, e.g. fetch-to-decode and LSU request queues. The read side is the consumer counterpart to the codebase's load-enabled register primitives: the write side captures data, and the read side presents and retires it in order. Storage is reset-free. Pointers, count and status flags are reset.

Parameters:
DW, 32, data width in bits (>=1)
DP, 4, depth in entries (power of two, >=2)
AW, 2, pointer width = log2(DP); must be set consistently with DP

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset), sampled on rising clk
flush  input  1  synchronous clear of FIFO contents; has priority over push/pop
i_vld  input  1  write side: producer has data
i_rdy  output  1  write side: FIFO accepts data (= not full)
i_dat  input  DW  write data
o_vld  output  1  read side: head entry valid (= not empty)
o_rdy  input  1  read side: consumer takes head entry
o_dat  output  DW  head entry data; forced to 0 when o_vld=0
count  output  AW+1  number of valid entries, 0..DP
ovf_err  output  1  sticky: push attempted while full
unf_err  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=0 at rising clk): wptr=0, rptr=0, count=0, ovf_err=0, unf_err=0. Outputs after reset: i_rdy=1, o_vld=0, o_dat=0. Storage is not cleared. Reset mid-transfer discards all entries. A push presented in the same cycle as reset is dropped.
- Pointers are AW+1 bits; the MSB is a wrap bit.
  - empty = (wptr == rptr)
  - full = (wptr[AW-1:0] == rptr[AW-1:0]) and (wptr[AW] != rptr[AW])
  - Pointers increment modulo 2^(AW+1), with natural wrap.
- push = i_vld & i_rdy. On push: mem[wptr[AW-1:0]] <= i_dat; wptr+1.
- pop = o_vld & o_rdy. On pop: rptr+1.
- i_rdy = ~full. o_vld = ~empty. Both are combinational from registered pointers only; there is no combinational path from i_vld/o_rdy to i_rdy/o_vld.
- o_dat = o_vld ? mem[rptr[AW-1:0]] : 0. The read is combinational from storage.
- Latency: data pushed at edge N is visible on o_dat with o_vld=1 after edge N. There is no same-cycle bypass when empty.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push and pop together, or neither
- Simultaneous push and pop:
  - Non-empty, non-full: both occur; count unchanged.
  - Full: push blocked (i_rdy=0); pop occurs.
  - Empty: pop blocked (o_vld=0); push occurs.
- Write-side producer rule: once i_vld=1, i_vld and i_dat are held until i_rdy=1. The FIFO does not check this.
- flush=1 (with rst=1): wptr=rptr=0, count=0 next cycle. Any same-cycle push or pop is discarded. Sticky error flags are unaffected.
- ovf_err set when i_vld=1 and full=1 at an edge. unf_err set when o_rdy=1 and empty=1 at an edge. Both cleared only by reset.
- Storage writes use a load-enabled, non-reset register per entry, enabled by push & (wptr index == entry).

Test Plan:
- Reset then idle, DW=32, DP=4: hold rst=0 for 2 cycles, then rst=1 -> i_rdy=1, o_vld=0, o_dat=0, count=0, ovf_err=0, unf_err=0.
- Fill and drain: push 0x11, 0x22, 0x33, 0x44 with o_rdy=0 -> count=4, i_rdy=0, o_dat=0x11. Then o_rdy=1 for 4 cycles -> o_dat sequence 0x11, 0x22, 0x33, 0x44, then o_vld=0, count=0.
- Wrap-around: 10 push/pop pairs with values 1..10, keeping occupancy at 1-2 -> output order 1..10 exact; pointers wrap past index 3 with no loss or duplication.
- Simultaneous push/pop at full: count=4, i_vld=1 with 0x55, o_rdy=1 -> 0x55 not accepted; head pops; count=3, i_rdy=1, ovf_err=1.
- Pop when empty: count=0, o_rdy=1 -> unf_err=1, count stays 0. Then i_vld=1 with 0xAA -> o_vld=1 next cycle, o_dat=0xAA.
- Flush and reset mid-operation:
  - count=3, flush=1 with i_vld=1 and o_rdy=1 -> next cycle count=0, o_vld=0, o_dat=0; sticky flags unchanged.
  - Refill to count=2, assert rst=0 for one cycle -> all state and flags return to reset values.

Source files
------------

// File: rtl/gnrl_sync_fifo_if.sv
// Valid/ready handshake bundle for gnrl_sync_fifo: write side (i_*) and read side (o_*).
// slave is the FIFO view; master is the producer/consumer view.
interface gnrl_sync_fifo_if #(
  parameter int DW = 32
);
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat
  );

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat
  );
endinterface

// File: rtl/gnrl_sync_fifo.sv
// Synchronous valid/ready FIFO with wrap-bit pointers, registered count and sticky
// overflow/underflow flags. Storage is reset-free; control state is reset.
module gnrl_sync_fifo #(
  parameter int DW = 32,
  parameter int DP = 4,
  parameter int AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  gnrl_sync_fifo_if.slave    bus,
  output logic [AW:0]        count,
  output logic               ovf_err,
  output logic               unf_err
);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf_err;
  logic          r_unf_err;
  logic [DW-1:0] r_mem [DP];

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_push  = bus.i_vld && !w_full;
  assign w_pop   = !w_empty && bus.o_rdy;
  // Writes are suppressed under reset/flush so discarded pushes never touch storage.
  assign w_wr_en = w_push && rst && !flush;

  assign bus.i_rdy = !w_full;
  assign bus.o_vld = !w_empty;
  assign bus.o_dat = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  assign count   = r_count;
  assign ovf_err = r_ovf_err;
  assign unf_err = r_unf_err;

  for (genvar g = 0; g < DP; g++) begin : g_entry
    always_ff @(posedge clk) begin
      if (w_wr_en && (r_wptr[AW-1:0] == AW'(g))) begin
        r_mem[g] <= bus.i_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  // Sticky flags: only reset clears them; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      if (bus.i_vld && w_full) begin
        r_ovf_err <= 1'b1;
      end
      if (bus.o_rdy && w_empty) begin
        r_unf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gnrl_sync_fifo.sv
// Self-checking bench for gnrl_sync_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_gnrl_sync_fifo;
  localparam int DW = 32;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [AW:0]   count;
  logic          ovf_err;
  logic          unf_err;

  gnrl_sync_fifo_if #(.DW(DW)) bus ();

  gnrl_sync_fifo #(.DW(DW), .DP(DP), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .count   (count),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  // Reference model: contents as a queue, flags as bits.
  logic [DW-1:0] m_q[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (bus.i_vld && m_q.size() == DP) m_ovf = 1'b1;
      if (bus.o_rdy && m_q.size() == 0)  m_unf = 1'b1;
      if (flush) begin
        m_q.delete();
      end else begin
        do_push = bus.i_vld && (m_q.size() < DP);
        do_pop  = bus.o_rdy && (m_q.size() > 0);
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(bus.i_dat);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("i_rdy",   64'(bus.i_rdy), 64'(m_q.size() < DP));
      check("o_vld",   64'(bus.o_vld), 64'(m_q.size() > 0));
      check("o_dat",   64'(bus.o_dat), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
      check("count",   64'(count),     64'(m_q.size()));
      check("ovf_err", 64'(ovf_err),   64'(m_ovf));
      check("unf_err", 64'(unf_err),   64'(m_unf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_i_rdy"},   64'(bus.i_rdy), 64'd1);
    check({tag, "_o_vld"},   64'(bus.o_vld), 64'd0);
    check({tag, "_o_dat"},   64'(bus.o_dat), 64'd0);
    check({tag, "_count"},   64'(count),     64'd0);
    check({tag, "_ovf"},     64'(ovf_err),   64'd0);
    check({tag, "_unf"},     64'(unf_err),   64'd0);
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    bus.i_vld = 1'b1;
    bus.i_dat = d;
    step();
    bus.i_vld = 1'b0;
  endtask

  initial begin
    bit held;
    rst = 1'b0;
    flush = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_dat = '0;
    bus.o_rdy = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk_en = 1'b1;
    check_reset_state("rst0");

    // fill and drain
    push_one(32'h11);
    push_one(32'h22);
    push_one(32'h33);
    push_one(32'h44);
    check("fill_count", 64'(count),     64'd4);
    check("fill_i_rdy", 64'(bus.i_rdy), 64'd0);
    check("fill_head",  64'(bus.o_dat), 64'h11);
    bus.o_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_dat", 64'(bus.o_dat), 64'(k * 32'h11));
      step();
    end
    bus.o_rdy = 1'b0;
    check("drain_o_vld", 64'(bus.o_vld), 64'd0);
    check("drain_count", 64'(count),     64'd0);

    // wrap-around with occupancy 1..2
    push_one(32'd1);
    bus.o_rdy = 1'b1;
    for (int v = 2; v <= 10; v++) begin
      bus.i_vld = 1'b1;
      bus.i_dat = 32'(v);
      check("wrap_dat", 64'(bus.o_dat), 64'(v - 1));
      step();
    end
    bus.i_vld = 1'b0;
    check("wrap_last", 64'(bus.o_dat), 64'd10);
    step();
    bus.o_rdy = 1'b0;
    check("wrap_empty", 64'(bus.o_vld), 64'd0);

    // push+pop while full
    for (int k = 1; k <= 4; k++) push_one(32'h60 + 32'(k));
    bus.i_vld = 1'b1;
    bus.i_dat = 32'h55;
    bus.o_rdy = 1'b1;
    step();
    bus.i_vld = 1'b0;
    bus.o_rdy = 1'b0;
    check("full_count", 64'(count),     64'd3);
    check("full_i_rdy", 64'(bus.i_rdy), 64'd1);
    check("full_ovf",   64'(ovf_err),   64'd1);
    check("full_head",  64'(bus.o_dat), 64'h62);
    bus.o_rdy = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      check("full_drain", 64'(bus.o_dat), 64'h60 + 64'(k));
      step();
    end
    bus.o_rdy = 1'b0;
    check("full_no55", 64'(bus.o_vld), 64'd0);

    // pop while empty
    bus.o_rdy = 1'b1;
    step();
    bus.o_rdy = 1'b0;
    check("unf_flag",  64'(unf_err), 64'd1);
    check("unf_count", 64'(count),   64'd0);
    push_one(32'hAA);
    check("aa_vld", 64'(bus.o_vld), 64'd1);
    check("aa_dat", 64'(bus.o_dat), 64'hAA);

    // flush with simultaneous push/pop
    push_one(32'hB1);
    push_one(32'hB2);
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    bus.i_vld = 1'b1;
    bus.i_dat = 32'hCC;
    bus.o_rdy = 1'b1;
    step();
    flush = 1'b0;
    bus.i_vld = 1'b0;
    bus.o_rdy = 1'b0;
    check("flush_count", 64'(count),     64'd0);
    check("flush_o_vld", 64'(bus.o_vld), 64'd0);
    check("flush_o_dat", 64'(bus.o_dat), 64'd0);
    check("flush_ovf",   64'(ovf_err),   64'd1);
    check("flush_unf",   64'(unf_err),   64'd1);

    // reset mid-operation with a push in the reset cycle
    push_one(32'hD1);
    push_one(32'hD2);
    check("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b0;
    bus.i_vld = 1'b1;
    bus.i_dat = 32'hEE;
    step();
    rst = 1'b1;
    bus.i_vld = 1'b0;
    check_reset_state("rst1");

    // randomized traffic; producer holds i_vld/i_dat until accepted
    for (int c = 0; c < 3000; c++) begin
      held = bus.i_vld && !bus.i_rdy && rst && !flush;
      @(posedge clk);
      #1;
      rst   = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 63) == 0);
      if (!held) begin
        bus.i_vld = ($urandom_range(0, 99) < 55);
        bus.i_dat = $urandom();
      end
      bus.o_rdy = ($urandom_range(0, 99) < 50);
    end
    step();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
